uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one serial byte transmitter between two byte-stream requesters: s0 (keypad/echo path) and s1 (periodic status source).
- Grants the transmitter for a whole frame, round-robin between requesters, and releases it on the frame's last byte or on a stall timeout.
- Sets the transmitter's bit period (baud_div) from the board switches; changes take effect only between frames.
- Sits between the requesters and the transmitter in the top level; the transmitter drives the JB/JC serial pins.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz (20 ns period).
- TIMEOUT_CYC, 1000000, number of idle cycles inside a granted frame before forced release (20 ms).
- DW, 8, data width of the byte streams.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s0_valid  in  1  requester 0 has a byte.
- s0_data  in  DW  requester 0 byte.
- s0_last  in  1  requester 0 byte is the last of its frame.
- s0_ready  out  1  requester 0 byte accepted this cycle.
- s1_valid, s1_data, s1_last, s1_ready  same as s0, for requester 1.
- rate_sel  in  3  baud select from SW[2:0].
- tx_valid  out  1  byte offered to transmitter.
- tx_data  out  DW  byte to transmitter.
- tx_ready  in  1  transmitter accepts the byte.
- baud_div  out  16  clocks per serial bit.
- grant  out  2  one-hot owner; 00 when idle.
- busy  out  1  a frame is granted.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset values:
  - state=IDLE, grant=00, busy=0, timeout_err=0.
  - tx_valid=0, s0_ready=0, s1_ready=0.
  - rr pointer=1, so s0 wins the first tie.
  - baud_div=434 (115200 baud); the select input is not sampled during reset.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - baud_div loads from the table every cycle.
  - If exactly one s*_valid is high, go to that GNTx next cycle.
  - If both are high, grant the requester that was NOT served last.
  - No data passes through in IDLE, so a grant costs 1 cycle of latency.
- GNTx data path (combinational pass-through):
  - tx_valid = sx_valid, tx_data = sx_data, sx_ready = tx_ready & sx_valid.
  - The other requester's ready is held at 0.
  - tx_data = 0 whenever tx_valid = 0.
- Frame end: a handshake (sx_valid & tx_ready) with sx_last=1 moves the block to IDLE next cycle and sets rr pointer=x.
  - Back-to-back frames from the same requester therefore have a 1-cycle gap and lose to a pending other requester.
- Timeout:
  - In GNTx, a 20-bit counter increments on each cycle with sx_valid=0 and clears on any cycle with sx_valid=1.
  - A cycle with sx_valid=1 and tx_ready=0 is a transmitter stall, not a requester stall, and clears the counter.
  - When the counter reaches TIMEOUT_CYC-1, go to IDLE next cycle, pulse timeout_err for 1 cycle and set rr pointer=x.
  - The counter is cleared on every entry to GNTx.
- baud_div table, computed as (CLK_HZ + baud/2)/baud:
  - 0: 5208 (9600)
  - 1: 2604 (19200)
  - 2: 1302 (38400)
  - 3: 868 (57600)
  - 4: 434 (115200)
  - 5: 217 (230400)
  - 6: 109 (460800)
  - 7: 54 (921600)
  - The value is frozen while busy=1; a rate_sel change mid-frame applies after return to IDLE.
- Simultaneous events:
  - last-byte handshake in the same cycle as the timeout threshold: treat as a normal frame end, no timeout_err.
  - New valid from the other requester during GNTx: ignored until IDLE.
- Reset mid-frame: outputs drop to reset values immediately (asynchronous); the in-flight byte is not acknowledged.

Test Plan:
- rst pulse, rate_sel=3'b100 -> baud_div=434, grant=00, all ready/valid=0 until release.
- s0 sends 3 bytes 0x41,0x42,0x43 (last on third), tx_ready=1 -> grant=01 one cycle after valid; tx_data shows the 3 bytes on consecutive cycles; grant=00 the cycle after 0x43.
- s0 and s1 both valid with 2-byte frames, from reset -> s0 frame served first, then s1; repeat with both valid -> s1 served first this time (alternates).
- In GNT1 after 1 byte, s1_valid drops, TIMEOUT_CYC=16 -> timeout_err high for exactly 1 cycle, 16 cycles after the drop; grant=00; s0 granted next if valid.
- rate_sel changed 4->0 mid-frame -> baud_div stays 434 until frame end, then 5208 one cycle after IDLE entry.
- Assert rst while tx_valid=1 mid-frame -> tx_valid, s*_ready, busy drop to 0 immediately; the next frame after release starts with s0 priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one serial byte transmitter between two byte-stream
// requesters. Ownership is held for a whole frame, handed out round-robin, and
// released on the last byte of the frame or after a requester stall. The
// transmitter bit period is chosen from the board switches and only changes
// between frames.
module uart_tx_arbiter #(
    parameter int CLK_HZ      = 50000000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int DW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data,
    input  logic          s0_last,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data,
    input  logic          s1_last,
    output logic          s1_ready,
    input  logic [2:0]    rate_sel,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
    output logic [15:0]   baud_div,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          timeout_err
);

    // Rounded clocks-per-bit for a given baud rate.
    function automatic logic [15:0] baud_calc(input int baud);
        return 16'((CLK_HZ + baud / 2) / baud);
    endfunction

    localparam logic [15:0] BAUD_DIV_9600   = baud_calc(9600);
    localparam logic [15:0] BAUD_DIV_19200  = baud_calc(19200);
    localparam logic [15:0] BAUD_DIV_38400  = baud_calc(38400);
    localparam logic [15:0] BAUD_DIV_57600  = baud_calc(57600);
    localparam logic [15:0] BAUD_DIV_115200 = baud_calc(115200);
    localparam logic [15:0] BAUD_DIV_230400 = baud_calc(230400);
    localparam logic [15:0] BAUD_DIV_460800 = baud_calc(460800);
    localparam logic [15:0] BAUD_DIV_921600 = baud_calc(921600);

    // Last idle count before a granted frame is forcibly released.
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);

    // Switch setting to bit period.
    function automatic logic [15:0] baud_lookup(input logic [2:0] sel);
        logic [15:0] div;
        case (sel)
            3'd0:    div = BAUD_DIV_9600;
            3'd1:    div = BAUD_DIV_19200;
            3'd2:    div = BAUD_DIV_38400;
            3'd3:    div = BAUD_DIV_57600;
            3'd4:    div = BAUD_DIV_115200;
            3'd5:    div = BAUD_DIV_230400;
            3'd6:    div = BAUD_DIV_460800;
            3'd7:    div = BAUD_DIV_921600;
            default: div = BAUD_DIV_115200;
        endcase
        return div;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t        r_state;
    logic [1:0]    r_grant;
    logic          r_busy;
    logic          r_timeout_err;
    logic          r_rr;          // id of the requester served last
    logic [19:0]   r_cnt;         // idle cycles inside the current frame
    logic [15:0]   r_baud_div;

    logic          w_own_valid;
    logic          w_own_last;
    logic          w_own_id;
    logic          w_hs_last;
    logic          w_timeout;

    // Select the handshake signals of the current owner.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_id    = 1'b0;
        case (r_state)
            ST_GNT0: begin
                w_own_valid = s0_valid;
                w_own_last  = s0_last;
                w_own_id    = 1'b0;
            end
            ST_GNT1: begin
                w_own_valid = s1_valid;
                w_own_last  = s1_last;
                w_own_id    = 1'b1;
            end
            default: begin
                w_own_valid = 1'b0;
                w_own_last  = 1'b0;
                w_own_id    = 1'b0;
            end
        endcase
    end

    // A last-byte handshake wins over a timeout landing on the same cycle.
    assign w_hs_last = w_own_valid & tx_ready & w_own_last;
    assign w_timeout = (r_cnt == TO_LAST) & ~w_hs_last;

    // Pass the owner's byte stream straight through to the transmitter.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = {DW{1'b0}};
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        case (r_state)
            ST_GNT0: begin
                tx_valid = s0_valid;
                tx_data  = s0_valid ? s0_data : {DW{1'b0}};
                s0_ready = tx_ready & s0_valid;
            end
            ST_GNT1: begin
                tx_valid = s1_valid;
                tx_data  = s1_valid ? s1_data : {DW{1'b0}};
                s1_ready = tx_ready & s1_valid;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = {DW{1'b0}};
            end
        endcase
    end

    // Ownership FSM: arbitration, frame end, stall timeout and baud latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= 2'b00;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rr          <= 1'b1;
            r_cnt         <= 20'd0;
            r_baud_div    <= BAUD_DIV_115200;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_baud_div <= baud_lookup(rate_sel);
                    r_cnt      <= 20'd0;
                    if (s0_valid && (!s1_valid || r_rr)) begin
                        r_state <= ST_GNT0;
                        r_grant <= 2'b01;
                        r_busy  <= 1'b1;
                    end else if (s1_valid) begin
                        r_state <= ST_GNT1;
                        r_grant <= 2'b10;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (w_hs_last || w_timeout) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= 2'b00;
                        r_busy        <= 1'b0;
                        r_rr          <= w_own_id;
                        r_cnt         <= 20'd0;
                        r_timeout_err <= w_timeout;
                    end else if (w_own_valid) begin
                        r_cnt <= 20'd0;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_cnt   <= 20'd0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign baud_div    = r_baud_div;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short stall timeout (16 cycles).
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       s0_valid, s0_last, s0_ready;
    logic [7:0] s0_data;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] s1_data;
    logic [2:0] rate_sel;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic [15:0] baud_div;
    logic [1:0] grant;
    logic       busy, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(
        .CLK_HZ(50000000),
        .TIMEOUT_CYC(16),
        .DW(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
        .rate_sel(rate_sel),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .baud_div(baud_div), .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drv0(input logic v, input logic [7:0] d, input logic l);
        s0_valid = v; s0_data = d; s0_last = l;
    endtask

    task automatic drv1(input logic v, input logic [7:0] d, input logic l);
        s1_valid = v; s1_data = d; s1_last = l;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_txv"}, 32'(tx_valid), 32'h0);
        chk({tag, "_txd"}, 32'(tx_data), 32'h0);
        chk({tag, "_rdy"}, {30'd0, s1_ready, s0_ready}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; rate_sel = 3'd0; tx_ready = 1'b0;
        drv0(1'b0, 8'h00, 1'b0);
        drv1(1'b0, 8'h00, 1'b0);

        // Reset: rate_sel not sampled while rst is high
        step(); step();
        chk("rst_baud", 32'(baud_div), 32'd434);
        chk("rst_to", 32'(timeout_err), 32'h0);
        chk_idle("rst");
        rate_sel = 3'd4;
        rst = 1'b0;
        step();
        chk("rel_baud", 32'(baud_div), 32'd434);

        // s0 three-byte frame
        tx_ready = 1'b1;
        drv0(1'b1, 8'h41, 1'b0); settle();
        chk_idle("s0_lat");
        step();
        chk("s0_g1", 32'(grant), 32'h1);
        chk("s0_busy", 32'(busy), 32'h1);
        chk("s0_d41", 32'(tx_data), 32'h41);
        chk("s0_rdy", 32'(s0_ready), 32'h1);
        step(); drv0(1'b1, 8'h42, 1'b0); settle();
        chk("s0_d42", 32'(tx_data), 32'h42);
        step(); drv0(1'b1, 8'h43, 1'b1); settle();
        chk("s0_d43", 32'(tx_data), 32'h43);
        step(); drv0(1'b0, 8'h00, 1'b0); settle();
        chk_idle("s0_end");

        // Reset pulse so round-robin starts fresh
        rst = 1'b1; step(); rst = 1'b0;

        // Both valid from reset: s0 first
        drv0(1'b1, 8'hA0, 1'b0); drv1(1'b1, 8'hB0, 1'b0); settle();
        chk_idle("rr_lat");
        step();
        chk("rr_g0", 32'(grant), 32'h1);
        chk("rr_a0", 32'(tx_data), 32'hA0);
        chk("rr_s1rdy0", 32'(s1_ready), 32'h0);
        step(); drv0(1'b1, 8'hA1, 1'b1); settle();
        chk("rr_a1", 32'(tx_data), 32'hA1);
        // s0 immediately offers another frame; pending s1 must win
        step(); drv0(1'b1, 8'hA2, 1'b1); settle();
        chk_idle("rr_gap");
        step();
        chk("rr_g1", 32'(grant), 32'h2);
        chk("rr_b0", 32'(tx_data), 32'hB0);
        chk("rr_s0rdy0", 32'(s0_ready), 32'h0);
        chk("rr_s1rdy", 32'(s1_ready), 32'h1);
        step(); drv1(1'b1, 8'hB1, 1'b1); settle();
        chk("rr_b1", 32'(tx_data), 32'hB1);
        step(); drv1(1'b0, 8'h00, 1'b0); settle();
        chk("rr_gap2", 32'(grant), 32'h0);
        step();
        chk("rr_g0b", 32'(grant), 32'h1);
        chk("rr_a2", 32'(tx_data), 32'hA2);
        // Second tie: s0 served last, so s1 wins
        step(); drv0(1'b1, 8'hA3, 1'b1); drv1(1'b1, 8'hB2, 1'b1); settle();
        chk("rr2_idle", 32'(grant), 32'h0);
        step();
        chk("rr2_g1", 32'(grant), 32'h2);
        chk("rr2_b2", 32'(tx_data), 32'hB2);
        step(); drv1(1'b0, 8'h00, 1'b0); settle();
        step();
        chk("rr2_g0", 32'(grant), 32'h1);
        chk("rr2_a3", 32'(tx_data), 32'hA3);
        step(); drv0(1'b0, 8'h00, 1'b0); settle();
        chk_idle("rr2_end");

        // Timeout: s1 sends one byte then stalls; s0 waits
        drv1(1'b1, 8'hC0, 1'b0); settle();
        step();
        chk("to_g1", 32'(grant), 32'h2);
        chk("to_c0", 32'(tx_data), 32'hC0);
        drv0(1'b1, 8'hD0, 1'b1);
        step(); drv1(1'b0, 8'h00, 1'b0); settle();
        chk("to_txv0", 32'(tx_valid), 32'h0);
        chk("to_s0rdy", 32'(s0_ready), 32'h0);
        for (int k = 1; k < 16; k++) begin
            step();
            chk("to_wait_err", 32'(timeout_err), 32'h0);
            chk("to_wait_g", 32'(grant), 32'h2);
        end
        step();
        chk("to_pulse", 32'(timeout_err), 32'h1);
        chk("to_rel_g", 32'(grant), 32'h0);
        chk("to_rel_busy", 32'(busy), 32'h0);
        step();
        chk("to_pulse_end", 32'(timeout_err), 32'h0);
        chk("to_next_g0", 32'(grant), 32'h1);
        chk("to_d0", 32'(tx_data), 32'hD0);
        step(); drv0(1'b0, 8'h00, 1'b0); settle();
        chk_idle("to_end");

        // Baud change mid-frame with a transmitter stall
        drv0(1'b1, 8'hE0, 1'b0); tx_ready = 1'b0; settle();
        chk("bd_pre", 32'(baud_div), 32'd434);
        step(); rate_sel = 3'd0; settle();
        chk("bd_stall_txv", 32'(tx_valid), 32'h1);
        chk("bd_stall_rdy", 32'(s0_ready), 32'h0);
        chk("bd_frz1", 32'(baud_div), 32'd434);
        step(); tx_ready = 1'b1; settle();
        chk("bd_rdy", 32'(s0_ready), 32'h1);
        chk("bd_frz2", 32'(baud_div), 32'd434);
        step(); drv0(1'b1, 8'hE1, 1'b1); settle();
        chk("bd_e1", 32'(tx_data), 32'hE1);
        step(); drv0(1'b0, 8'h00, 1'b0); settle();
        chk("bd_idle_g", 32'(grant), 32'h0);
        chk("bd_idle_div", 32'(baud_div), 32'd434);
        step(); rate_sel = 3'd3; settle();
        chk("bd_5208", 32'(baud_div), 32'd5208);
        step(); rate_sel = 3'd7; settle();
        chk("bd_868", 32'(baud_div), 32'd868);
        step();
        chk("bd_54", 32'(baud_div), 32'd54);

        // Reset mid-frame: outputs drop at once, s0 regains priority
        drv0(1'b1, 8'hF0, 1'b0); settle();
        step();
        chk("mr_txv", 32'(tx_valid), 32'h1);
        #3; rst = 1'b1; #1;
        chk_idle("mr_rst");
        chk("mr_baud", 32'(baud_div), 32'd434);
        step(); rst = 1'b0;
        drv0(1'b1, 8'h60, 1'b1); drv1(1'b1, 8'h70, 1'b1); settle();
        chk("mr_idle", 32'(grant), 32'h0);
        step();
        chk("mr_g0", 32'(grant), 32'h1);
        chk("mr_d60", 32'(tx_data), 32'h60);
        chk("mr_baud54", 32'(baud_div), 32'd54);
        step(); drv0(1'b0, 8'h00, 1'b0); settle();
        step();
        chk("mr_g1", 32'(grant), 32'h2);
        chk("mr_d70", 32'(tx_data), 32'h70);
        step(); drv1(1'b0, 8'h00, 1'b0); settle();
        chk_idle("mr_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
